// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage:
// FSM state encoding, UART addresses, bus widths and the UART status helper.
package mem_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [AW-1:0] UART_STAT_ADDR = 16'hBF01;

  function automatic logic [DW-1:0] uart_status(
    input logic dready,
    input logic tbre,
    input logic tsre
  );
    return {{(DW-2){1'b0}}, dready, tbre & tsre};
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Bus-wait watchdog: counts enabled cycles since the last clear.
// Ports: clk_i, rst_i (sync, high), clr_i, en_i, expire_o (fires on the LIMIT-th enabled cycle).
module mem_watchdog
#(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // cnt_q holds the number of earlier idle BUSY cycles.
  assign expire_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: load/store -> req/ack bus transaction, local UART status.
// Ports: CLK, RST (sync, high); memread_i/memwrite_i/addr_i/wdata_i from EX/MEM;
// uart_*_i status lines; mem_req_o/we_o/addr_o/wdata_o, mem_ack_i/rdata_i bus;
// memres_o to MEM/WB; stall_o; err_o. Bus watchdog compiled in with MEM_TIMEOUT_EN.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] UART_STAT_ADDR = mem_pkg::UART_STAT_ADDR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic        uart_tbre_i,
  input  logic        uart_tsre_i,
  input  logic        uart_dready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_rdata_i,
  output logic [15:0] memres_o,
  output logic        stall_o,
  output logic        err_o
);

  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] data_q, data_d;

  logic access, is_local, bus_acc, start, expire;

  assign access   = memread_i | memwrite_i;
  assign is_local = access && (addr_i == UART_STAT_ADDR);
  assign bus_acc  = access && !is_local;
  assign start    = (state_q == S_IDLE) && bus_acc;

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (16)
  ) u_wd (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (start),
    .en_i     ((state_q == S_BUSY) && !mem_ack_i),
    .expire_o (expire)
  );

  always_ff @(posedge CLK) begin
    if (RST)         err_q <= 1'b0;
    else if (expire) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus_acc) begin
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = memwrite_i;
          req_d   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Ack beats a same-cycle timeout.
        if (mem_ack_i) begin
          if (!we_q) data_d = mem_rdata_i;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (expire) begin
          data_d  = '1;
          req_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  assign stall_o = start || (state_q == S_BUSY);

  always_comb begin
    memres_o = '0;
    if (state_q == S_DONE) begin
      memres_o = we_q ? '0 : data_q;
    end else if ((state_q == S_IDLE) && is_local && !memwrite_i) begin
      memres_o = uart_status(uart_dready_i, uart_tbre_i, uart_tsre_i);
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed accesses push expectations,
// a negedge monitor pops and compares when a result is presented.
module tb_mem_access;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        memread_i = 1'b0;
  logic        memwrite_i = 1'b0;
  logic [15:0] addr_i = '0;
  logic [15:0] wdata_i = '0;
  logic        uart_tbre_i = 1'b0;
  logic        uart_tsre_i = 1'b0;
  logic        uart_dready_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [15:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [15:0] mem_rdata_i = 16'hDEAD;
  logic [15:0] memres_o;
  logic        stall_o, err_o;

  always #5 CLK = ~CLK;

  mem_access #(
    .TIMEOUT_CYCLES (4),
    .UART_STAT_ADDR (16'hBF01)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .memread_i     (memread_i),
    .memwrite_i    (memwrite_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .uart_tbre_i   (uart_tbre_i),
    .uart_tsre_i   (uart_tsre_i),
    .uart_dready_i (uart_dready_i),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .memres_o      (memres_o),
    .stall_o       (stall_o),
    .err_o         (err_o)
  );

  typedef struct {
    string       name;
    logic [15:0] res;
    int          stalls;
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bus responder
  int          busy_cnt = 0;
  int          ack_delay = 1;
  logic [15:0] rd_val = '0;
  bit          resp_en = 1'b1;
  logic        force_ack = 1'b0;

  always @(negedge CLK) begin
    if (!resp_en) begin
      mem_ack_i   = force_ack;
      mem_rdata_i = 16'hDEAD;
      busy_cnt    = 0;
    end else if (mem_req_o) begin
      busy_cnt++;
      if (busy_cnt == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd_val;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = 16'hDEAD;
      end
    end else begin
      busy_cnt    = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 16'hDEAD;
    end
  end

  // Request pulse / gap tracker
  int pulses = 0;
  int low_run = 0;
  int min_gap = 999;
  bit prev_req = 1'b0;

  always @(negedge CLK) begin
    if (mem_req_o && !prev_req) begin
      pulses++;
      if (pulses > 1 && low_run < min_gap) min_gap = low_run;
    end
    low_run  = mem_req_o ? 0 : low_run + 1;
    prev_req = mem_req_o;
  end

  // Monitor
  int st_cnt = 0;
  bit saw_req = 1'b0;
  bit bus_bad = 1'b0;
  bit got = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    if (RST || !(memread_i | memwrite_i)) begin
      st_cnt = 0; saw_req = 0; bus_bad = 0;
    end else begin
      if (mem_req_o) begin
        saw_req = 1'b1;
        if (sb.size() > 0 &&
            (mem_addr_o !== sb[0].addr || mem_we_o !== sb[0].we ||
             mem_wdata_o !== sb[0].wdata))
          bus_bad = 1'b1;
      end
      if (stall_o) begin
        st_cnt++;
      end else begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_result: got %h with nothing expected",
                   memres_o);
        end else begin
          e = sb.pop_front();
          check({e.name, "_res"}, memres_o, e.res);
          check({e.name, "_stalls"}, st_cnt, e.stalls);
          check({e.name, "_req"}, saw_req, e.req);
          if (e.req) check({e.name, "_bus_stable"}, bus_bad, 0);
          check({e.name, "_err"}, err_o, e.err);
        end
        got = 1'b1;
        st_cnt = 0; saw_req = 0; bus_bad = 0;
      end
    end
  end

  task automatic do_access(input string name, input bit rd, input bit wr,
                           input logic [15:0] a, input logic [15:0] wd,
                           input int dly, input logic [15:0] rv,
                           input logic [15:0] res, input int stalls,
                           input bit req, input bit err);
    exp_t e;
    bit   done;
    e.name = name; e.res = res; e.stalls = stalls; e.req = req;
    e.we = wr; e.addr = a; e.wdata = wd; e.err = err;
    ack_delay = dly;
    rd_val = rv;
    got = 1'b0;
    done = 1'b0;
    sb.push_back(e);
    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge CLK);
      if (got) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL %s_wait: no result within 40 cycles, stall=%b", name,
               stall_o);
      sb.delete();
    end
    #1;
    memread_i = 0; memwrite_i = 0; addr_i = '0; wdata_i = '0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 16'h0000);
    check("rst_wdata", mem_wdata_o, 16'h0000);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_res", memres_o, 16'h0000);
    memread_i = 1; addr_i = 16'h4000;
    #1;
    check("rst_stall_comb", stall_o, 1);
    memread_i = 0; addr_i = '0;
    @(posedge CLK);
    #1;
    RST = 0;

    // Loads / stores through the bus
    do_access("ld4000", 1, 0, 16'h4000, 16'h0000, 1, 16'hBEEF,
              16'hBEEF, 2, 1, 0);
    do_access("st8001", 0, 1, 16'h8001, 16'h1234, 3, 16'h5555,
              16'h0000, 4, 1, 0);

    // UART status served locally
    uart_dready_i = 1; uart_tbre_i = 1; uart_tsre_i = 0;
    do_access("stat_a", 1, 0, 16'hBF01, 16'h0000, 1, 16'h0,
              16'h0002, 0, 0, 0);
    uart_dready_i = 0; uart_tbre_i = 1; uart_tsre_i = 1;
    do_access("stat_b", 1, 0, 16'hBF01, 16'h0000, 1, 16'h0,
              16'h0001, 0, 0, 0);
    uart_dready_i = 1;
    do_access("st_stat", 0, 1, 16'hBF01, 16'hAAAA, 1, 16'h0,
              16'h0000, 0, 0, 0);
    do_access("ld_bf00", 1, 0, 16'hBF00, 16'h0000, 1, 16'h00C3,
              16'h00C3, 2, 1, 0);

    // read+write together is a store
    do_access("rdwr", 1, 1, 16'h5000, 16'h0F0F, 2, 16'h7777,
              16'h0000, 3, 1, 0);

    // No access
    @(posedge CLK);
    #1;
    check("idle_stall", stall_o, 0);
    check("idle_res", memres_o, 16'h0000);

    // Reset in the second BUSY cycle, then a late ack
    resp_en = 0; force_ack = 0;
    memread_i = 1; addr_i = 16'h2000;
    @(posedge CLK);
    #1;
    check("mr_req_busy", mem_req_o, 1);
    @(posedge CLK);
    #1;
    RST = 1; memread_i = 0; addr_i = '0;
    @(posedge CLK);
    #1;
    check("mr_req_after_rst", mem_req_o, 0);
    check("mr_stall_after_rst", stall_o, 0);
    RST = 0; force_ack = 1;
    @(posedge CLK);
    #1;
    force_ack = 0;
    @(posedge CLK);
    #1;
    check("mr_late_ack_req", mem_req_o, 0);
    check("mr_late_ack_res", memres_o, 16'h0000);
    resp_en = 1;
    do_access("after_rst", 1, 0, 16'h0020, 16'h0000, 1, 16'h5A5A,
              16'h5A5A, 2, 1, 0);

    // Back-to-back loads
    pulses = 0; min_gap = 999;
    do_access("b2b_0", 1, 0, 16'h0010, 16'h0000, 1, 16'h1111,
              16'h1111, 2, 1, 0);
    do_access("b2b_1", 1, 0, 16'h0011, 16'h0000, 2, 16'h2222,
              16'h2222, 3, 1, 0);
    check("b2b_pulses", pulses, 2);
    check("b2b_gap", min_gap, 2);

`ifdef MEM_TIMEOUT_EN
    resp_en = 0; force_ack = 0;
    do_access("tmo", 1, 0, 16'h3000, 16'h0000, 1, 16'h0,
              16'hFFFF, 5, 1, 1);
    repeat (3) @(posedge CLK);
    #1;
    check("tmo_err_sticky", err_o, 1);
    check("tmo_req_low", mem_req_o, 0);
    RST = 1;
    @(posedge CLK);
    #1;
    RST = 0;
    check("tmo_err_cleared", err_o, 0);
    resp_en = 1;
`else
    check("err_tied", err_o, 0);
`endif

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
